// File: rtl/repetition_pkg.sv
// Shared defaults for the repetition detector.
package repetition_pkg;

  localparam int unsigned REP_FIELD_SIZE = 16;
  localparam int unsigned REP_WINDOW     = 8;

endpackage

// File: rtl/rep_history.sv
// Sliding history of recently accepted fields with parallel match against the incoming value.
module rep_history
  import repetition_pkg::*;
#(
  parameter int unsigned Width = REP_FIELD_SIZE,
  parameter int unsigned Depth = REP_WINDOW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             flush_i,
  input  logic [Width-1:0] data_i,
  output logic             hit_o
);

  logic [Depth-1:0][Width-1:0] data_q, data_d;
  logic [Depth-1:0]            occ_q, occ_d;

  // Match: any occupied entry equal to the incoming value; empty slots never match.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (occ_q[i] && (data_q[i] == data_i)) begin
        hit_o = 1'b1;
      end
    end
  end

  // Next state: flush empties the history; a push in the same cycle still lands in slot 0.
  always_comb begin
    data_d = data_q;
    occ_d  = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end
    if (push_i) begin
      for (int i = int'(Depth) - 1; i > 0; i--) begin
        data_d[i] = data_q[i-1];
        occ_d[i]  = flush_i ? 1'b0 : occ_q[i-1];
      end
      data_d[0] = data_i;
      occ_d[0]  = 1'b1;
    end
  end

  // History registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/repetition_counter.sv
// Counts accepted fields that repeat a value seen within the last WINDOW accepted fields.
module repetition_counter
  import repetition_pkg::*;
#(
  parameter int unsigned FIELD_SIZE = REP_FIELD_SIZE,
  parameter int unsigned WINDOW     = REP_WINDOW
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [FIELD_SIZE-1:0] field,
  output logic [FIELD_SIZE-1:0] rep_rate
);

  logic                  hit;
  logic [FIELD_SIZE-1:0] cnt_q, cnt_d;

  rep_history #(
    .Width (FIELD_SIZE),
    .Depth (WINDOW)
  ) u_history (
    .clk_i   (sys_clk),
    .rst_ni  (reset_n),
    .push_i  (valid),
    .flush_i (clear),
    .data_i  (field),
    .hit_o   (hit)
  );

  // Counter: clear wins and the sample it carries is never compared; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (valid && hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rep_rate = cnt_q;

endmodule

// File: tb/tb_repetition_counter.sv
// Scoreboard bench for repetition_counter (16-bit/8-deep instance plus a 4-bit instance for saturation).
module tb_repetition_counter;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear   = 1'b0;
  logic        valid   = 1'b0;
  logic [15:0] field   = '0;
  logic [15:0] rep_rate;
  logic [3:0]  rep_rate4;

  int tests_run = 0;
  int failures  = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  exp4_q[$];

  always #5 sys_clk = ~sys_clk;

  repetition_counter #(
    .FIELD_SIZE (16),
    .WINDOW     (8)
  ) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .valid    (valid),
    .field    (field),
    .rep_rate (rep_rate)
  );

  repetition_counter #(
    .FIELD_SIZE (4),
    .WINDOW     (8)
  ) dut4 (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .valid    (valid),
    .field    (field[3:0]),
    .rep_rate (rep_rate4)
  );

  // Drive one cycle of stimulus and record what rep_rate must show after the edge.
  task automatic step(input logic v, input logic c, input logic [15:0] f, input logic [15:0] e);
    valid = v;
    clear = c;
    field = f;
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
    valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid   = 1'b0;
    clear   = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    do_reset();
    got = rep_rate;
    tests_run++;
    if (got !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d want 0", got);
    end
  endtask

  task automatic test_distinct();
    logic [15:0] got, e;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 16'(i), 16'd0);
      got = rep_rate; e = exp_q.pop_front(); tests_run++;
      if (got !== e) begin
        failures++;
        $display("FAIL distinct[%0d]: got %0d want %0d", i, got, e);
      end
    end
  endtask

  task automatic test_repeat();
    logic [15:0] got, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'd5, 16'(i));
      got = rep_rate; e = exp_q.pop_front(); tests_run++;
      if (got !== e) begin
        failures++;
        $display("FAIL repeat[%0d]: got %0d want %0d", i, got, e);
      end
    end
  endtask

  task automatic test_window_edge();
    logic [15:0] got, e;
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i), 16'd0);
    step(1'b1, 1'b0, 16'd1, 16'd1);
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      if (i == 8) begin
        got = rep_rate; tests_run++;
        if (got !== e) begin
          failures++;
          $display("FAIL window_inside: got %0d want %0d", got, e);
        end
      end
    end
    do_reset();
    for (int i = 10; i <= 18; i++) step(1'b1, 1'b0, 16'(i), 16'd0);
    step(1'b1, 1'b0, 16'd10, 16'd0);
    for (int i = 0; i < 10; i++) e = exp_q.pop_front();
    got = rep_rate; tests_run++;
    if (got !== e) begin
      failures++;
      $display("FAIL window_aged_out: got %0d want %0d", got, e);
    end
  endtask

  task automatic test_clear();
    logic [15:0] got, e;
    do_reset();
    step(1'b1, 1'b0, 16'd7, 16'd0);
    e = exp_q.pop_front();
    step(1'b1, 1'b0, 16'd7, 16'd1);
    got = rep_rate; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin failures++; $display("FAIL clear_pre: got %0d want %0d", got, e); end
    step(1'b1, 1'b1, 16'd7, 16'd0);
    got = rep_rate; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin failures++; $display("FAIL clear_valid: got %0d want %0d", got, e); end
    step(1'b1, 1'b0, 16'd7, 16'd1);
    got = rep_rate; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin failures++; $display("FAIL clear_post: got %0d want %0d", got, e); end
    // Clear without valid empties history: a following 7 must not count.
    step(1'b0, 1'b1, 16'd7, 16'd0);
    got = rep_rate; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin failures++; $display("FAIL clear_only: got %0d want %0d", got, e); end
    step(1'b1, 1'b0, 16'd7, 16'd0);
    got = rep_rate; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin failures++; $display("FAIL clear_flushed: got %0d want %0d", got, e); end
  endtask

  task automatic test_gaps();
    logic [15:0] got, e;
    do_reset();
    step(1'b1, 1'b0, 16'd3, 16'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'd9, 16'd0);
    for (int i = 0; i < 4; i++) begin
      got = 16'd0; e = exp_q.pop_front();
    end
    step(1'b1, 1'b0, 16'd3, 16'd1);
    got = rep_rate; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin failures++; $display("FAIL gap_repeat: got %0d want %0d", got, e); end
    step(1'b1, 1'b0, 16'd9, 16'd1);
    got = rep_rate; e = exp_q.pop_front(); tests_run++;
    if (got !== e) begin failures++; $display("FAIL gap_ignored: got %0d want %0d", got, e); end
  endtask

  task automatic test_saturation();
    logic [3:0]  got4, e4;
    logic [15:0] got, e;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp4_q.push_back((i > 15) ? 4'd15 : 4'(i));
      step(1'b1, 1'b0, 16'd0, 16'(i));
      got4 = rep_rate4; e4 = exp4_q.pop_front(); e = exp_q.pop_front();
      if (i >= 14) begin
        tests_run++;
        if (got4 !== e4) begin
          failures++;
          $display("FAIL saturate[%0d]: got %0d want %0d", i, got4, e4);
        end
      end
    end
    // Asynchronous reset mid-cycle, checked before any further clock edge.
    valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    got4 = rep_rate4; got = rep_rate; tests_run++;
    if (got4 !== 4'd0 || got !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: got %0d/%0d want 0/0", got4, got);
    end
    valid = 1'b0;
    @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
    exp4_q.push_back(4'd0);
    step(1'b1, 1'b0, 16'd0, 16'd0);
    got4 = rep_rate4; e4 = exp4_q.pop_front(); e = exp_q.pop_front(); tests_run++;
    if (got4 !== e4) begin
      failures++;
      $display("FAIL post_reset: got %0d want %0d", got4, e4);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got, e;
    logic [15:0] pat [8];
    logic [15:0] want [8];
    pat  = '{16'd4, 16'd9, 16'd4, 16'd4, 16'd9, 16'd1, 16'd2, 16'd1};
    want = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd4};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, pat[i], want[i]);
      got = rep_rate; e = exp_q.pop_front(); tests_run++;
      if (got !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got %0d want %0d", i, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_repeat();
    test_window_edge();
    test_clear();
    test_gaps();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
